ysyx_24100029_axi_sram: RTL and testbench

AXI4 responder that backs the core's memory masters (the LSU and the fetch path) with an on-chip word-addressed SRAM, completing the other end of the master-side AW/W/B/AR/R channels. Accepts one transaction at a time, with single-beat or FIXED/INCR bursts. Programmable read and write latency emulates real memory timing. Returns byte-lane-correct data with ID echo and OKAY/SLVERR responses.

---
 rtl/ysyx_24100029_axi_pkg.sv | 27 ++
 rtl/ysyx_24100029_sram_array.sv | 30 +++
 rtl/ysyx_24100029_axi_sram.sv | 191 +++++++++++++++++++
 tb/tb_ysyx_24100029_axi_sram.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100029_axi_pkg.sv
// Shared definitions for the AXI4 SRAM responder: response codes, burst
// codes, the responder FSM state encoding and the burst address step.
package ysyx_24100029_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_LAT  = 3'd1,
    ST_RD_BEAT = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_LAT  = 3'd4,
    ST_WR_RESP = 3'd5
  } state_t;

  // FIXED keeps the address; INCR and WRAP both step one word.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_24100029_sram_array.sv
// Word-addressed SRAM, DEPTH_WORDS x 32, one shared index port.
//   clock  : write clock
//   index  : word index (driven from a register in the parent, so the
//            combinational read behaves like a registered-address read)
//   wbe    : per-byte write enable, lane i = wdata[8i+7:8i]
//   wdata  : write data, lanes in place
//   rdata  : combinational read of mem[index]
// Contents are never reset.
module ysyx_24100029_sram_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic [AW-1:0] index,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wbe[i]) mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/ysyx_24100029_axi_sram.sv
// AXI4 responder backed by an on-chip SRAM. One transaction at a time,
// single-beat or FIXED/INCR (WRAP treated as INCR) bursts, programmable
// read/write latency, byte-lane writes, OKAY/SLVERR responses, ID echo.
//   clock, reset          : single clock, synchronous active-low reset
//   aw*/w*/b*             : write address, write data, write response
//   ar*/r*                : read address, read data
//   dbg_state             : current FSM state, for observation only
//
// Handshake rule for every channel: a transfer happens on a rising edge
// where valid and ready are both 1. Our valids (rvalid, bvalid) come only
// from registered state, never from the same-cycle ready, and once raised
// they and their payload hold until the transfer completes. Our readies
// never wait for the master's valid, except arready which drops whenever
// awvalid is high so a simultaneous write wins.
module ysyx_24100029_axi_sram
  import ysyx_24100029_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  output state_t      dbg_state
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [7:0]  RD_LAT_M1 = (RD_LAT > 0) ? 8'(RD_LAT - 1) : 8'd0;
  localparam logic [7:0]  WR_LAT_M1 = (WR_LAT > 0) ? 8'(WR_LAT - 1) : 8'd0;

  state_t      state_q, state_d;
  logic        live_q;     // low for the first cycle after reset release
  logic [31:0] addr_q;     // current beat address
  logic [3:0]  id_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [7:0]  lat_q;      // remaining latency cycles minus one
  logic [1:0]  burst_q;
  logic        err_q;      // sticky write error

  logic [31:0] off;
  logic        in_range;
  logic [AW-1:0] index;
  logic [31:0] mem_rdata;
  logic [3:0]  wbe;
  logic        aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic        unused_size;

  assign unused_size = ^{awsize, arsize};

  // Unsigned wrap makes addresses below ADDR_BASE land far above SPAN.
  assign off      = addr_q - ADDR_BASE;
  assign in_range = off < SPAN;
  assign index    = off[AW+1:2];

  assign awready = live_q && (state_q == ST_IDLE);
  assign arready = live_q && (state_q == ST_IDLE) && !awvalid;
  assign wready  = (state_q == ST_WR_DATA);
  assign rvalid  = (state_q == ST_RD_BEAT);
  assign bvalid  = (state_q == ST_WR_RESP);

  assign aw_hs = awvalid && awready;
  assign ar_hs = arvalid && arready;
  assign w_hs  = wvalid && wready;
  assign r_hs  = rvalid && rready;
  assign b_hs  = bvalid && bready;

  assign rdata = (rvalid && in_range) ? mem_rdata : 32'd0;
  assign rresp = (rvalid && !in_range) ? RESP_SLVERR : RESP_OKAY;
  assign rlast = rvalid && (beat_q == len_q);
  assign rid   = rvalid ? id_q : 4'd0;
  assign bresp = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign bid   = bvalid ? id_q : 4'd0;

  assign wbe       = (w_hs && in_range) ? wstrb : 4'd0;
  assign dbg_state = state_q;

  ysyx_24100029_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clock (clock),
    .index (index),
    .wbe   (wbe),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (aw_hs)      state_d = ST_WR_DATA;
        else if (ar_hs) state_d = (RD_LAT > 0) ? ST_RD_LAT : ST_RD_BEAT;
      end
      ST_RD_LAT:  if (lat_q == 8'd0) state_d = ST_RD_BEAT;
      ST_RD_BEAT: if (r_hs && (beat_q == len_q)) state_d = ST_IDLE;
      ST_WR_DATA: if (w_hs && wlast) state_d = (WR_LAT > 0) ? ST_WR_LAT : ST_WR_RESP;
      ST_WR_LAT:  if (lat_q == 8'd0) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
      addr_q  <= 32'd0;
      id_q    <= 4'd0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      lat_q   <= 8'd0;
      burst_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (aw_hs) begin
            addr_q  <= awaddr;
            id_q    <= awid;
            len_q   <= awlen;
            burst_q <= awburst;
            beat_q  <= 8'd0;
            err_q   <= 1'b0;
          end else if (ar_hs) begin
            addr_q  <= araddr;
            id_q    <= arid;
            len_q   <= arlen;
            burst_q <= arburst;
            beat_q  <= 8'd0;
            lat_q   <= RD_LAT_M1;
          end
        end
        ST_RD_LAT: lat_q <= lat_q - 8'd1;
        ST_RD_BEAT: begin
          if (r_hs) begin
            addr_q <= next_addr(addr_q, burst_q);
            beat_q <= beat_q + 8'd1;
          end
        end
        ST_WR_DATA: begin
          if (w_hs) begin
            addr_q <= next_addr(addr_q, burst_q);
            beat_q <= beat_q + 8'd1;
            // Dropped out-of-range beat, or wlast not on beat awlen.
            if (!in_range || (wlast && (beat_q != len_q))) err_q <= 1'b1;
            if (wlast) lat_q <= WR_LAT_M1;
          end
        end
        ST_WR_LAT: lat_q <= lat_q - 8'd1;
        ST_WR_RESP: if (b_hs) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_axi_sram.sv
// Directed plus randomized bench for ysyx_24100029_axi_sram. The reference
// model is a plain word array updated per beat from the address/strobe rules.
module tb_ysyx_24100029_axi_sram;
  import ysyx_24100029_axi_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          RDL   = 2;
  localparam int          WRL   = 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  state_t      dbg_state;

  ysyx_24100029_axi_sram #(
    .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(RDL), .WR_LAT(WRL)
  ) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [31:0] mem_m [DEPTH];

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 32'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 2;
    return int'(o);
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 32'd4;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mem_m[widx(a)][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_awready"}, 32'(awready), 32'd0);
    check({tag, "_arready"}, 32'(arready), 32'd0);
    check({tag, "_wready"},  32'(wready),  32'd0);
    check({tag, "_bvalid"},  32'(bvalid),  32'd0);
    check({tag, "_rvalid"},  32'(rvalid),  32'd0);
    check({tag, "_rlast"},   32'(rlast),   32'd0);
    check({tag, "_bresp"},   32'(bresp),   32'd0);
    check({tag, "_rresp"},   32'(rresp),   32'd0);
    check({tag, "_bid"},     32'(bid),     32'd0);
    check({tag, "_rid"},     32'(rid),     32'd0);
    check({tag, "_rdata"},   rdata,        32'd0);
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] rbuf [256];
  logic [1:0]  rrbuf[256];
  logic        rlbuf[256];

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int nbeats,
                          input logic [7:0] len, input logic [1:0] burst, input int bstall,
                          input bit ar_race, output logic [1:0] resp, output logic [3:0] bid_o,
                          output int lat);
    int g;
    int m;
    logic [31:0] a;
    @(negedge clock);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = 3'd2;
    if (ar_race) begin
      arvalid = 1'b1; araddr = addr; arid = ~id; arlen = 8'd0; arburst = BURST_INCR;
      #1;
      check("race_arready", 32'(arready), 32'd0);
      check("race_awready", 32'(awready), 32'd1);
    end
    g = 0;
    while (!awready && g < 50) begin @(negedge clock); g++; end
    check("aw_ready", 32'(awready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    awvalid = 1'b0;
    arvalid = 1'b0;
    a = addr;
    for (int b = 0; b < nbeats; b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == nbeats - 1);
      g = 0;
      while (!wready && g < 50) begin @(negedge clock); g++; end
      check("w_ready", 32'(wready), 32'd1);
      @(posedge clock);
      model_write(a, wbuf[b], sbuf[b]);
      a = step(a, burst);
      @(negedge clock);
    end
    wvalid = 1'b0; wlast = 1'b0;
    m = cyc;
    g = 0;
    while (!bvalid && g < 50) begin @(negedge clock); g++; end
    check("b_valid", 32'(bvalid), 32'd1);
    lat = cyc - m;
    resp = bresp;
    bid_o = bid;
    for (int s = 0; s < bstall; s++) begin
      @(negedge clock);
      check("b_hold_valid", 32'(bvalid), 32'd1);
      check("b_hold_resp", 32'(bresp), 32'(resp));
      check("b_hold_id", 32'(bid), 32'(bid_o));
    end
    bready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bready = 1'b0;
    check("b_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input int stall_beat, input int stall_n,
                         output int lat);
    int g;
    int n;
    lat = -1;
    @(negedge clock);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst; arsize = 3'd2;
    rready = 1'b1;
    g = 0;
    while (!arready && g < 50) begin @(negedge clock); g++; end
    check("ar_ready", 32'(arready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    arvalid = 1'b0;
    n = cyc;
    for (int b = 0; b <= int'(len); b++) begin
      g = 0;
      while (!rvalid && g < 50) begin @(negedge clock); g++; end
      check("r_valid", 32'(rvalid), 32'd1);
      if (b == 0) lat = cyc - n;
      rbuf[b] = rdata; rrbuf[b] = rresp; rlbuf[b] = rlast;
      check("r_id", 32'(rid), 32'(id));
      if (b == stall_beat && stall_n > 0) begin
        rready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clock);
          check("r_hold_valid", 32'(rvalid), 32'd1);
          check("r_hold_data", rdata, rbuf[b]);
          check("r_hold_last", 32'(rlast), 32'(rlbuf[b]));
          check("r_hold_resp", 32'(rresp), 32'(rrbuf[b]));
        end
        rready = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
    end
    rready = 1'b0;
    check("r_drop", 32'(rvalid), 32'd0);
  endtask

  // Compare captured beats against the model.
  task automatic verify_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
    logic [31:0] a;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      if (in_rng(a)) begin
        check({tag, "_data"}, rbuf[b], mem_m[widx(a)]);
        check({tag, "_resp"}, 32'(rrbuf[b]), 32'(RESP_OKAY));
      end else begin
        check({tag, "_data"}, rbuf[b], 32'd0);
        check({tag, "_resp"}, 32'(rrbuf[b]), 32'(RESP_SLVERR));
      end
      check({tag, "_last"}, 32'(rlbuf[b]), 32'(b == int'(len)));
      a = step(a, burst);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0]  resp;
    logic [3:0]  bid_o;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          lat;

    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

    // Reset: all outputs 0, readies appear one cycle after release.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle_zero("rst");
    reset = 1'b1;
    check("rel_awready_early", 32'(awready), 32'd0);
    @(negedge clock);
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_arready", 32'(arready), 32'd1);

    // Preload words 0..63 with one long INCR burst.
    for (int w = 0; w < 64; w++) begin wbuf[w] = $urandom; sbuf[w] = 4'hf; end
    wbuf[0] = 32'h1122_3344;
    do_write(BASE, 4'd1, 64, 8'd63, BURST_INCR, 0, 1'b0, resp, bid_o, lat);
    check("pre_bresp", 32'(resp), 32'(RESP_OKAY));
    check("pre_bid", 32'(bid_o), 32'd1);
    check("pre_wlat", 32'(lat), 32'(WRL));

    // Byte-lane write with unaligned address.
    wbuf[0] = 32'h0000_AB00; sbuf[0] = 4'b0010;
    do_write(BASE + 32'd1, 4'd5, 1, 8'd0, BURST_INCR, 2, 1'b0, resp, bid_o, lat);
    check("lane_bresp", 32'(resp), 32'(RESP_OKAY));
    check("lane_bid", 32'(bid_o), 32'd5);

    // Single read: latency, rlast, rid, merged data.
    do_read(BASE, 4'd9, 8'd0, BURST_INCR, 0, 0, lat);
    check("lane_rdata", rbuf[0], 32'h1122_AB44);
    check("single_rlat", 32'(lat), 32'(RDL));
    verify_read("single", BASE, 8'd0, BURST_INCR);

    // INCR burst of 4 with a 2-cycle stall on beat 1.
    do_read(BASE + 32'h10, 4'd6, 8'd3, BURST_INCR, 1, 2, lat);
    verify_read("burst4", BASE + 32'h10, 8'd3, BURST_INCR);

    // FIXED read burst re-reads one word.
    do_read(BASE + 32'h20, 4'd2, 8'd2, BURST_FIXED, 0, 0, lat);
    verify_read("fixed", BASE + 32'h20, 8'd2, BURST_FIXED);

    // AW and AR together to the same address: write first, read sees it.
    wbuf[0] = 32'hCAFE_F00D; sbuf[0] = 4'hf;
    do_write(BASE + 32'h24, 4'd7, 1, 8'd0, BURST_INCR, 0, 1'b1, resp, bid_o, lat);
    check("race_bresp", 32'(resp), 32'(RESP_OKAY));
    do_read(BASE + 32'h24, 4'd8, 8'd0, BURST_INCR, 0, 0, lat);
    check("race_rdata", rbuf[0], 32'hCAFE_F00D);

    // Out-of-range read below the base.
    do_read(32'h7FFF_FFFC, 4'd3, 8'd0, BURST_INCR, 0, 0, lat);
    check("oor_rd_resp", 32'(rrbuf[0]), 32'(RESP_SLVERR));
    check("oor_rd_data", rbuf[0], 32'd0);

    // Out-of-range write just past the end: SLVERR, word 0 untouched.
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'hf;
    do_write(BASE + 32'(4 * DEPTH), 4'd4, 1, 8'd0, BURST_INCR, 0, 1'b0, resp, bid_o, lat);
    check("oor_wr_resp", 32'(resp), 32'(RESP_SLVERR));
    check("oor_wr_bid", 32'(bid_o), 32'd4);
    do_read(BASE, 4'd1, 8'd0, BURST_INCR, 0, 0, lat);
    verify_read("oor_wr_keep", BASE, 8'd0, BURST_INCR);

    // Burst running off the top of memory: last word OK, next SLVERR.
    wbuf[0] = 32'h5A5A_1234; sbuf[0] = 4'hf;
    do_write(BASE + 32'(4 * (DEPTH - 1)), 4'd2, 1, 8'd0, BURST_INCR, 0, 1'b0, resp, bid_o, lat);
    check("top_wr_resp", 32'(resp), 32'(RESP_OKAY));
    do_read(BASE + 32'(4 * (DEPTH - 1)), 4'd2, 8'd1, BURST_INCR, 0, 0, lat);
    verify_read("top_rd", BASE + 32'(4 * (DEPTH - 1)), 8'd1, BURST_INCR);

    // Early wlast: beats still land, response is SLVERR.
    wbuf[0] = 32'h0101_0101; wbuf[1] = 32'h0202_0202; sbuf[0] = 4'hf; sbuf[1] = 4'hf;
    do_write(BASE + 32'd40, 4'd11, 2, 8'd2, BURST_INCR, 0, 1'b0, resp, bid_o, lat);
    check("short_resp", 32'(resp), 32'(RESP_SLVERR));
    check("short_bid", 32'(bid_o), 32'd11);
    do_read(BASE + 32'd40, 4'd0, 8'd1, BURST_INCR, 0, 0, lat);
    verify_read("short_rd", BASE + 32'd40, 8'd1, BURST_INCR);

    // Reset during read latency: transaction dropped, no rvalid.
    @(negedge clock);
    arvalid = 1'b1; araddr = BASE + 32'd8; arid = 4'd3; arlen = 8'd0; arburst = BURST_INCR;
    rready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    arvalid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_idle_zero("rst_mid");
    repeat (3) begin
      @(negedge clock);
      check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    end
    reset = 1'b1;
    rready = 1'b0;
    @(negedge clock);
    check("rst_mid_arready", 32'(arready), 32'd1);
    check("rst_mid_rvalid2", 32'(rvalid), 32'd0);
    do_read(BASE + 32'd8, 4'd12, 8'd0, BURST_INCR, 0, 0, lat);
    verify_read("after_rst", BASE + 32'd8, 8'd0, BURST_INCR);
    check("after_rst_lat", 32'(lat), 32'(RDL));

    // Random traffic within the preloaded region.
    for (int it = 0; it < 40; it++) begin
      addr  = BASE + 32'(4 * $urandom_range(0, 56)) + 32'($urandom_range(0, 3));
      len   = 8'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 2));
      id    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= int'(len); b++) begin
          wbuf[b] = $urandom; sbuf[b] = 4'($urandom_range(0, 15));
        end
        do_write(addr, id, int'(len) + 1, len, burst, $urandom_range(0, 2), 1'b0,
                 resp, bid_o, lat);
        check("rnd_bresp", 32'(resp), 32'(RESP_OKAY));
        check("rnd_bid", 32'(bid_o), 32'(id));
        check("rnd_wlat", 32'(lat), 32'(WRL));
      end else begin
        do_read(addr, id, len, burst, $urandom_range(0, int'(len)), $urandom_range(0, 2), lat);
        verify_read("rnd_rd", addr, len, burst);
        check("rnd_rlat", 32'(lat), 32'(RDL));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
